// File: rtl/store_load_buffer_if.sv
// store_load_buffer_if: dispatch, commit broadcast, memory and ROB writeback signals of the store/load buffer
interface store_load_buffer_if #(
    parameter int TAG_W = 4
);
    logic             rdy;
    logic             clear;
    logic             iss_valid;
    logic             iss_is_store;
    logic [2:0]       iss_funct3;
    logic [TAG_W-1:0] iss_rob;
    logic [31:0]      iss_vj;
    logic [31:0]      iss_vk;
    logic             iss_qj_v;
    logic             iss_qk_v;
    logic [TAG_W-1:0] iss_qj;
    logic [TAG_W-1:0] iss_qk;
    logic [31:0]      iss_imm;
    logic             full;
    logic             empty;
    logic             cdb_valid;
    logic [TAG_W-1:0] cdb_tag;
    logic [31:0]      cdb_value;
    logic             st_go;
    logic [TAG_W-1:0] st_go_tag;
    logic             mem_req;
    logic             mem_we;
    logic [31:0]      mem_addr;
    logic [31:0]      mem_wdata;
    logic [1:0]       mem_size;
    logic             mem_done;
    logic [31:0]      mem_rdata;
    logic             wb_valid;
    logic [TAG_W-1:0] wb_rob;
    logic [31:0]      wb_value;

    modport slave (
        input  rdy, clear, iss_valid, iss_is_store, iss_funct3, iss_rob, iss_vj, iss_vk,
               iss_qj_v, iss_qk_v, iss_qj, iss_qk, iss_imm, cdb_valid, cdb_tag, cdb_value,
               st_go, st_go_tag, mem_done, mem_rdata,
        output full, empty, mem_req, mem_we, mem_addr, mem_wdata, mem_size,
               wb_valid, wb_rob, wb_value
    );

    modport master (
        output rdy, clear, iss_valid, iss_is_store, iss_funct3, iss_rob, iss_vj, iss_vk,
               iss_qj_v, iss_qk_v, iss_qj, iss_qk, iss_imm, cdb_valid, cdb_tag, cdb_value,
               st_go, st_go_tag, mem_done, mem_rdata,
        input  full, empty, mem_req, mem_we, mem_addr, mem_wdata, mem_size,
               wb_valid, wb_rob, wb_value
    );
endinterface

// File: rtl/store_load_buffer.sv
// store_load_buffer: in-order memory op queue with operand wake-up, ROB-gated stores and one outstanding memory access
module store_load_buffer #(
    parameter int DEPTH = 16,
    parameter int TAG_W = 4
) (
    input logic clk,
    input logic rst,
    store_load_buffer_if.slave bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    typedef enum logic [1:0] {IDLE, MEM, DRAIN} state_t;

    state_t           state;
    logic [AW-1:0]    head, tail;
    logic [CW-1:0]    count;
    logic [DEPTH-1:0] busy, is_store, qj_v, qk_v, go;
    logic [2:0]       funct3 [DEPTH];
    logic [TAG_W-1:0] rob [DEPTH];
    logic [TAG_W-1:0] qj [DEPTH];
    logic [TAG_W-1:0] qk [DEPTH];
    logic [31:0]      vj [DEPTH];
    logic [31:0]      vk [DEPTH];
    logic [31:0]      imm [DEPTH];
    logic             push, pop, launch, j_byp, k_byp;

    function automatic logic [31:0] load_ext(input logic [2:0] f, input logic [31:0] d);
        return f == 3'b000 ? {{24{d[7]}}, d[7:0]} :
               f == 3'b001 ? {{16{d[15]}}, d[15:0]} :
               f == 3'b100 ? {24'b0, d[7:0]} :
               f == 3'b101 ? {16'b0, d[15:0]} : d;
    endfunction

    assign bus.full  = count == CW'(DEPTH);
    assign bus.empty = count == '0;
    assign push   = bus.iss_valid && !bus.full;
    assign pop    = state == MEM && bus.mem_done;
    assign launch = busy[head] && !qj_v[head] && (!is_store[head] || (!qk_v[head] && go[head]));
    assign j_byp  = bus.iss_qj_v && bus.cdb_valid && bus.iss_qj == bus.cdb_tag;
    assign k_byp  = bus.iss_qk_v && bus.cdb_valid && bus.iss_qk == bus.cdb_tag;

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= IDLE;
            head          <= '0;
            tail          <= '0;
            count         <= '0;
            busy          <= '0;
            go            <= '0;
            bus.mem_req   <= 1'b0;
            bus.mem_we    <= 1'b0;
            bus.mem_addr  <= '0;
            bus.mem_wdata <= '0;
            bus.mem_size  <= '0;
            bus.wb_valid  <= 1'b0;
            bus.wb_rob    <= '0;
            bus.wb_value  <= '0;
        end else if (bus.rdy) begin
            bus.wb_valid <= 1'b0;
            if (bus.clear) begin
                head  <= '0;
                tail  <= '0;
                count <= '0;
                busy  <= '0;
                go    <= '0;
                // an access already on the bus must still complete, but its result is dropped
                if (state != IDLE && bus.mem_done) begin
                    state       <= IDLE;
                    bus.mem_req <= 1'b0;
                end else if (state == MEM) begin
                    state <= DRAIN;
                end
            end else begin
                for (int i = 0; i < DEPTH; i++) begin
                    if (bus.cdb_valid && busy[i] && qj_v[i] && qj[i] == bus.cdb_tag) begin
                        vj[i]   <= bus.cdb_value;
                        qj_v[i] <= 1'b0;
                    end
                    if (bus.cdb_valid && busy[i] && qk_v[i] && qk[i] == bus.cdb_tag) begin
                        vk[i]   <= bus.cdb_value;
                        qk_v[i] <= 1'b0;
                    end
                    if (bus.st_go && busy[i] && is_store[i] && rob[i] == bus.st_go_tag)
                        go[i] <= 1'b1;
                end
                if (push) begin
                    busy[tail]     <= 1'b1;
                    go[tail]       <= 1'b0;
                    is_store[tail] <= bus.iss_is_store;
                    funct3[tail]   <= bus.iss_funct3;
                    rob[tail]      <= bus.iss_rob;
                    imm[tail]      <= bus.iss_imm;
                    qj[tail]       <= bus.iss_qj;
                    qk[tail]       <= bus.iss_qk;
                    vj[tail]       <= j_byp ? bus.cdb_value : bus.iss_vj;
                    vk[tail]       <= k_byp ? bus.cdb_value : bus.iss_vk;
                    qj_v[tail]     <= bus.iss_qj_v && !j_byp;
                    qk_v[tail]     <= bus.iss_qk_v && !k_byp;
                    tail           <= tail + AW'(1);
                end
                if (pop) begin
                    busy[head] <= 1'b0;
                    go[head]   <= 1'b0;
                    head       <= head + AW'(1);
                end
                count <= count + CW'(push) - CW'(pop);
                case (state)
                    IDLE: if (launch) begin
                        state         <= MEM;
                        bus.mem_req   <= 1'b1;
                        bus.mem_we    <= is_store[head];
                        bus.mem_addr  <= vj[head] + imm[head];
                        bus.mem_size  <= funct3[head][1:0];
                        bus.mem_wdata <= vk[head];
                    end
                    MEM: if (bus.mem_done) begin
                        state        <= IDLE;
                        bus.mem_req  <= 1'b0;
                        bus.wb_valid <= 1'b1;
                        bus.wb_rob   <= rob[head];
                        bus.wb_value <= is_store[head] ? 32'd0 : load_ext(funct3[head], bus.mem_rdata);
                    end
                    default: if (bus.mem_done) begin
                        state       <= IDLE;
                        bus.mem_req <= 1'b0;
                    end
                endcase
            end
        end
    end
endmodule

// File: tb/tb_store_load_buffer.sv
// tb_store_load_buffer: directed scenarios plus randomized traffic against an in-order queue model
module tb_store_load_buffer;
    typedef struct {
        logic        st;
        logic [2:0]  f3;
        logic [3:0]  rob;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic        go;
        int          go_cyc;
    } op_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_chk = 0;
    int   n_pass = 0;

    op_t         q[$];
    op_t         cur, op, tmp;
    bit          outst[16];
    logic [31:0] tval[16];
    int          cand[$], fr[$];
    bit          inflight, drained, ewv, bcast, clr;
    logic [3:0]  ewr, seq;
    logic [31:0] ewval, rd, a, ad, d, dd;
    logic        ap, dp;
    logic [3:0]  at, dt;
    int          delay, bt, sz, f;

    store_load_buffer_if #(.TAG_W(4)) bus ();

    store_load_buffer #(.DEPTH(16), .TAG_W(4)) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    function automatic logic [31:0] ld_val(input logic [2:0] fn, input logic [31:0] data);
        logic [31:0] b, h;
        b = data & 32'hFF;
        h = data & 32'hFFFF;
        case (fn)
            3'd0:    return b >= 32'd128 ? b - 32'd256 : b;
            3'd1:    return h >= 32'd32768 ? h - 32'h10000 : h;
            3'd4:    return b;
            3'd5:    return h;
            default: return data;
        endcase
    endfunction

    task automatic idle();
        bus.rdy = 1; bus.clear = 0; bus.iss_valid = 0; bus.iss_is_store = 0; bus.iss_funct3 = 0;
        bus.iss_rob = 0; bus.iss_vj = 0; bus.iss_vk = 0; bus.iss_qj_v = 0; bus.iss_qk_v = 0;
        bus.iss_qj = 0; bus.iss_qk = 0; bus.iss_imm = 0; bus.cdb_valid = 0; bus.cdb_tag = 0;
        bus.cdb_value = 0; bus.st_go = 0; bus.st_go_tag = 0; bus.mem_done = 0; bus.mem_rdata = 0;
    endtask

    task automatic issue(input logic st, input logic [2:0] f3, input logic [3:0] r, input logic [31:0] va,
                         input logic jv, input logic [3:0] j, input logic [31:0] vd, input logic [31:0] im);
        bus.iss_valid = 1; bus.iss_is_store = st; bus.iss_funct3 = f3; bus.iss_rob = r;
        bus.iss_vj = va; bus.iss_qj_v = jv; bus.iss_qj = j; bus.iss_vk = vd;
        bus.iss_qk_v = 0; bus.iss_qk = 0; bus.iss_imm = im;
        @(negedge clk);
        bus.iss_valid = 0; bus.cdb_valid = 0;
    endtask

    task automatic wait_req(input string tag);
        int n;
        n = 0;
        while (!bus.mem_req && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk(tag, bus.mem_req, 1);
    endtask

    task automatic complete(input int dly, input logic [31:0] data);
        repeat (dly) @(negedge clk);
        bus.mem_done = 1; bus.mem_rdata = data;
        @(negedge clk);
        bus.mem_done = 0;
    endtask

    task automatic do_reset();
        rst = 1;
        idle();
        repeat (3) @(negedge clk);
        rst = 0;
    endtask

    task automatic pick(input bit allow, output logic [31:0] val, output logic [31:0] drv,
                        output logic pend, output logic [3:0] tag);
        int m, t0;
        m = allow ? int'($urandom_range(0, 3)) : 3;
        val = $urandom; drv = val; pend = 0; tag = 4'($urandom);
        if (m == 1 && bcast) begin
            pend = 1; tag = 4'(bt); val = tval[bt]; drv = $urandom;
        end else if (m == 0) begin
            fr.delete();
            for (int t = 0; t < 16; t++) if (!outst[t] && !(bcast && t == bt)) fr.push_back(t);
            if (fr.size() != 0) begin
                t0 = fr[$urandom_range(0, fr.size() - 1)];
                tval[t0] = $urandom; outst[t0] = 1;
                pend = 1; tag = 4'(t0); val = tval[t0]; drv = $urandom;
            end
        end
    endtask

    initial begin
        rst = 1;
        idle();
        repeat (3) @(negedge clk);
        chk("rst_full", bus.full, 0);
        chk("rst_empty", bus.empty, 1);
        chk("rst_req", bus.mem_req, 0);
        chk("rst_we", bus.mem_we, 0);
        chk("rst_addr", bus.mem_addr, 0);
        chk("rst_wdata", bus.mem_wdata, 0);
        chk("rst_size", bus.mem_size, 0);
        chk("rst_wbv", bus.wb_valid, 0);
        chk("rst_wbrob", bus.wb_rob, 0);
        chk("rst_wbval", bus.wb_value, 0);
        rst = 0;

        issue(0, 3'b010, 3, 32'h100, 0, 0, 0, 4);
        chk("lw_empty", bus.empty, 0);
        wait_req("lw_req");
        chk("lw_addr", bus.mem_addr, 32'h104);
        chk("lw_size", bus.mem_size, 2);
        chk("lw_we", bus.mem_we, 0);
        complete(1, 32'hDEADBEEF);
        chk("lw_req_drop", bus.mem_req, 0);
        chk("lw_wbv", bus.wb_valid, 1);
        chk("lw_wbrob", bus.wb_rob, 3);
        chk("lw_wbval", bus.wb_value, 32'hDEADBEEF);
        @(negedge clk);
        chk("lw_wb_pulse", bus.wb_valid, 0);
        chk("lw_empty2", bus.empty, 1);

        issue(0, 3'b000, 4, 32'h20, 0, 0, 0, 0);
        wait_req("lb_req");
        complete(0, 32'h000000F0);
        chk("lb_val", bus.wb_value, 32'hFFFFFFF0);
        issue(0, 3'b100, 4, 32'h20, 0, 0, 0, 0);
        wait_req("lbu_req");
        complete(0, 32'h000000F0);
        chk("lbu_val", bus.wb_value, 32'h000000F0);

        issue(1, 3'b010, 5, 32'h40, 0, 0, 32'h1234, 0);
        repeat (4) begin
            @(negedge clk);
            chk("st_gate", bus.mem_req, 0);
        end
        bus.st_go = 1; bus.st_go_tag = 5;
        @(negedge clk);
        bus.st_go = 0;
        wait_req("st_req");
        chk("st_we", bus.mem_we, 1);
        chk("st_addr", bus.mem_addr, 32'h40);
        chk("st_wdata", bus.mem_wdata, 32'h1234);
        complete(0, 32'hFFFFFFFF);
        chk("st_wbv", bus.wb_valid, 1);
        chk("st_wbrob", bus.wb_rob, 5);
        chk("st_wbval", bus.wb_value, 0);

        bus.cdb_valid = 1; bus.cdb_tag = 7; bus.cdb_value = 32'h200;
        issue(0, 3'b010, 2, 32'hBAD, 1, 7, 0, 32'h10);
        wait_req("byp_req");
        chk("byp_addr", bus.mem_addr, 32'h210);
        complete(0, 0);
        chk("byp_wbrob", bus.wb_rob, 2);

        do_reset();
        for (int i = 0; i < 16; i++)
            issue(0, 3'b010, 4'(i), i == 0 ? 32'h0 : 32'h1000 + 32'(4 * i), i == 0, 9, 0, 0);
        chk("fill_full", bus.full, 1);
        chk("fill_req", bus.mem_req, 0);
        issue(0, 3'b010, 15, 32'h9000, 0, 0, 0, 0);
        chk("drop_full", bus.full, 1);
        bus.cdb_valid = 1; bus.cdb_tag = 9; bus.cdb_value = 32'h1000;
        @(negedge clk);
        bus.cdb_valid = 0;
        wait_req("wrap_req0");
        chk("wrap_addr0", bus.mem_addr, 32'h1000);
        complete(0, 0);
        chk("pop_full", bus.full, 0);
        issue(0, 3'b010, 0, 32'h2000, 0, 0, 0, 0);
        chk("refill_full", bus.full, 1);
        for (int i = 1; i <= 16; i++) begin
            wait_req("wrap_req");
            chk("wrap_addr", bus.mem_addr, i < 16 ? 32'h1000 + 32'(4 * i) : 32'h2000);
            complete(0, 0);
            chk("wrap_rob", bus.wb_rob, i < 16 ? 32'(i) : 32'd0);
        end
        chk("wrap_empty", bus.empty, 1);

        issue(0, 3'b010, 1, 32'h300, 0, 0, 0, 0);
        issue(0, 3'b010, 2, 32'h400, 0, 0, 0, 0);
        wait_req("clr_req");
        chk("clr_addr", bus.mem_addr, 32'h300);
        bus.clear = 1;
        @(negedge clk);
        bus.clear = 0;
        chk("clr_empty", bus.empty, 1);
        chk("clr_hold", bus.mem_req, 1);
        repeat (2) begin
            @(negedge clk);
            chk("clr_hold", bus.mem_req, 1);
        end
        complete(0, 32'h55);
        chk("clr_req_drop", bus.mem_req, 0);
        chk("clr_no_wb", bus.wb_valid, 0);
        repeat (3) begin
            @(negedge clk);
            chk("clr_quiet_req", bus.mem_req, 0);
            chk("clr_quiet_wb", bus.wb_valid, 0);
        end

        do_reset();
        inflight = 0; drained = 0; ewv = 0; seq = 0; delay = 0; bt = 0;
        for (int t = 0; t < 16; t++) begin outst[t] = 0; tval[t] = 0; end
        for (int c = 0; c < 8000; c++) begin
            @(negedge clk);
            chk("full", bus.full, q.size() == 16);
            chk("empty", bus.empty, q.size() == 0);
            chk("wb_valid", bus.wb_valid, ewv);
            if (ewv) begin
                chk("wb_rob", bus.wb_rob, ewr);
                chk("wb_value", bus.wb_value, ewval);
            end
            if (!inflight) begin
                if (q.size() == 0) chk("req_idle", bus.mem_req, 0);
                else if (q[0].st && (!q[0].go || q[0].go_cyc == c - 1)) chk("st_hold", bus.mem_req, 0);
                else if (bus.mem_req) begin
                    cur = q[0];
                    chk("r_addr", bus.mem_addr, cur.addr);
                    chk("r_we", bus.mem_we, cur.st);
                    chk("r_size", bus.mem_size, cur.f3[1:0]);
                    if (cur.st) chk("r_wdata", bus.mem_wdata, cur.wdata);
                    inflight = 1; drained = 0; delay = $urandom_range(0, 3);
                end
            end
            if (c >= 3000 && q.size() == 0 && !inflight) break;
            idle();
            if ($urandom_range(0, 15) == 0) begin
                bus.rdy = 0;
                continue;
            end
            ewv = 0;
            sz = q.size();
            clr = c < 3000 && $urandom_range(0, 99) == 0;
            if (inflight && delay == 0) begin
                rd = $urandom;
                bus.mem_done = 1; bus.mem_rdata = rd;
                inflight = 0;
                if (!drained && !clr) begin
                    ewv = 1; ewr = cur.rob;
                    ewval = cur.st ? 32'd0 : ld_val(cur.f3, rd);
                    void'(q.pop_front());
                end
            end else if (inflight) delay--;
            if (clr) begin
                bus.clear = 1;
                q.delete();
                drained = inflight;
                continue;
            end
            bcast = 0;
            cand.delete();
            for (int t = 0; t < 16; t++) if (outst[t]) cand.push_back(t);
            if (cand.size() != 0 && $urandom_range(0, c < 3000 ? 2 : 0) == 0) begin
                bt = cand[$urandom_range(0, cand.size() - 1)];
                bcast = 1; outst[bt] = 0;
                bus.cdb_valid = 1; bus.cdb_tag = 4'(bt); bus.cdb_value = tval[bt];
            end
            if (q.size() != 0 && q[0].st && $urandom_range(0, c < 3000 ? 3 : 0) == 0) begin
                bus.st_go = 1; bus.st_go_tag = q[0].rob;
                if (!q[0].go) begin
                    tmp = q[0]; tmp.go = 1; tmp.go_cyc = c; q[0] = tmp;
                end
            end
            if (c < 3000 && $urandom_range(0, 1) == 0) begin
                op.st = $urandom_range(0, 2) == 0;
                f = $urandom_range(0, 4);
                op.f3 = op.st ? 3'(f % 3) : (f < 3 ? 3'(f) : 3'(f + 1));
                op.rob = seq; op.go = 0; op.go_cyc = 0;
                pick(1, a, ad, ap, at);
                pick(op.st, d, dd, dp, dt);
                bus.iss_valid = 1; bus.iss_is_store = op.st; bus.iss_funct3 = op.f3;
                bus.iss_rob = op.rob; bus.iss_imm = $urandom;
                bus.iss_vj = ad; bus.iss_qj_v = ap; bus.iss_qj = at;
                bus.iss_vk = dd; bus.iss_qk_v = dp; bus.iss_qk = dt;
                op.addr = a + bus.iss_imm;
                op.wdata = d;
                if (sz < 16) begin
                    q.push_back(op);
                    seq++;
                end
            end
        end
        idle();
        @(negedge clk);
        chk("end_empty", bus.empty, 1);
        chk("end_req", bus.mem_req, 0);
        chk("end_wb", bus.wb_valid, 0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
